// File: rtl/bcd_scan_display_if.sv
// Load/result bus between the calculator result register and the BCD display stage.
interface bcd_scan_display_if #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
);
  // Handshake: value is taken on a clock edge where value_valid=1 and busy=0.
  // A strobe seen while busy=1 is dropped, not queued. bcd/overflow change only
  // on the edge that drops busy.
  logic [WIDTH-1:0]    value;
  logic                value_valid;
  logic                busy;
  logic [4*DIGITS-1:0] bcd;
  logic                overflow;

  modport master (output value, value_valid, input busy, bcd, overflow);
  modport slave  (input value, value_valid, output busy, bcd, overflow);
endinterface

// File: rtl/bcd_scan_display.sv
// Binary to packed BCD (sequential double-dabble) plus a multiplexed common-anode 7-segment driver.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module bcd_scan_display #(
  parameter int WIDTH    = 10,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 10
) (
  input  logic                clk_in,
  input  logic                rst_n,
  bcd_scan_display_if.slave   bus,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   digit_en,
  output logic [1:0]          state_dbg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [31:0]      MAX_VAL  = 32'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0] BITS     = CNT_W'(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_DASH  = 7'b0111111;
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]       value_reg;
  logic [BCD_W-1:0]       scratch;
  logic [BCD_W-1:0]       adj;
  logic [BCD_W+WIDTH-1:0] shift_w;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   ovf_hold;
  logic [BCD_W-1:0]       bcd_q;
  logic                   ovf_q;
  logic                   busy_q;
  logic [SCAN_DIV-1:0]    scan_cnt;
  logic [IDX_W-1:0]       digit_idx;
  logic [3:0]             nibble;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.value_valid) state_nx = S_SHIFT;
      S_SHIFT: if (bit_cnt == CNT_W'(1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Add-3 correction on every nibble before the shift; the top bit shifted out
  // of the scratch is a carry worth 10**DIGITS and is intentionally dropped.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3
                                                  : scratch[4*i +: 4];
    end
  end

  assign shift_w = {adj[BCD_W-2:0], value_reg, 1'b0};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      ovf_hold  <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.value_valid) begin
            value_reg <= bus.value;
            scratch   <= '0;
            bit_cnt   <= BITS;
            ovf_hold  <= (32'(bus.value) > MAX_VAL);
            busy_q    <= 1'b1;
          end
        end
        S_SHIFT: begin
          scratch   <= shift_w[BCD_W+WIDTH-1:WIDTH];
          value_reg <= shift_w[WIDTH-1:0];
          bit_cnt   <= bit_cnt - CNT_W'(1);
        end
        S_DONE: begin
          bcd_q  <= scratch;
          ovf_q  <= ovf_hold;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt) begin
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  assign nibble = bcd_q[{digit_idx, 2'b00} +: 4];

  // seg and digit_en both derive from digit_idx, so they switch on the same edge.
  always_comb begin
    seg = seg_code(nibble);
`ifdef LEADING_ZERO_BLANK_EN
    if ((digit_idx != '0) && ((bcd_q >> {digit_idx, 2'b00}) == '0)) seg = SEG_BLANK;
`endif
    if (ovf_q) seg = SEG_DASH;
  end

  assign digit_en     = ~(DIGITS'(1) << digit_idx);
  assign bus.busy     = busy_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: a 4-digit and a 3-digit instance share one stimulus stream,
// checked every cycle against an arithmetic model plus literal expectations.
module tb_bcd_scan_display;
  localparam int WIDTH    = 10;
  localparam int SCAN_DIV = 2;

  // clock / reset
  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  logic [WIDTH-1:0] value       = '0;
  logic             value_valid = 1'b0;

  bcd_scan_display_if #(.WIDTH(WIDTH), .DIGITS(4)) if4 ();
  bcd_scan_display_if #(.WIDTH(WIDTH), .DIGITS(3)) if3 ();
  assign if4.value       = value;
  assign if4.value_valid = value_valid;
  assign if3.value       = value;
  assign if3.value_valid = value_valid;

  logic [6:0] seg4, seg3;
  logic [3:0] en4;
  logic [2:0] en3;
  logic [1:0] st4, st3;

  bcd_scan_display #(.WIDTH(WIDTH), .DIGITS(4), .SCAN_DIV(SCAN_DIV)) u4 (
    .clk_in(clk_in), .rst_n(rst_n), .bus(if4.slave),
    .seg(seg4), .digit_en(en4), .state_dbg(st4));
  bcd_scan_display #(.WIDTH(WIDTH), .DIGITS(3), .SCAN_DIV(SCAN_DIV)) u3 (
    .clk_in(clk_in), .rst_n(rst_n), .bus(if3.slave),
    .seg(seg3), .digit_en(en3), .state_dbg(st3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model helpers
  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] exp_bcd(input int val, input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) r = r | (32'((val / pow10(i)) % 10) << (4 * i));
    return r;
  endfunction

  function automatic logic [6:0] digit_code(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int val, input int d, input int idx);
    if (val > pow10(d) - 1) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (val % pow10(d)) < pow10(idx)) return 7'h7F;
`endif
    return digit_code((val / pow10(idx)) % 10);
  endfunction

  // behavioural model: cycle count since reset, busy window, latched value
  int m_n    = 0;
  bit m_busy = 1'b0;
  int m_rem  = 0;
  int m_val  = 0;
  int m_pend = 0;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_busy = 1'b0; m_rem = 0; m_val = 0; m_pend = 0;
    end else begin
      m_n = m_n + 1;
      if (m_busy) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_val  = m_pend;
        end
      end else if (value_valid) begin
        m_pend = int'(value);
        m_busy = 1'b1;
        m_rem  = WIDTH + 1;
      end
    end
  end

  // scoreboard compare, every cycle
  always begin
    int idx4, idx3;
    logic [3:0] e4;
    logic [2:0] e3;
    @(negedge clk_in);
    #1;
    idx4 = (m_n >> SCAN_DIV) % 4;
    idx3 = (m_n >> SCAN_DIV) % 3;
    e4 = ~(4'b0001 << idx4);
    e3 = ~(3'b001 << idx3);
    chk("busy4", 32'(if4.busy), 32'(m_busy));
    chk("bcd4",  32'(if4.bcd), exp_bcd(m_val, 4));
    chk("ovf4",  32'(if4.overflow), 32'(m_val > 9999));
    chk("seg4",  32'(seg4), 32'(exp_seg(m_val, 4, idx4)));
    chk("en4",   32'(en4), 32'(e4));
    chk("busy3", 32'(if3.busy), 32'(m_busy));
    chk("bcd3",  32'(if3.bcd), exp_bcd(m_val, 3));
    chk("ovf3",  32'(if3.overflow), 32'(m_val > 999));
    chk("seg3",  32'(seg3), 32'(exp_seg(m_val, 3, idx3)));
    chk("en3",   32'(en3), 32'(e3));
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic load(input int v);
    @(negedge clk_in);
    value       = WIDTH'(v);
    value_valid = 1'b1;
    @(negedge clk_in);
    value_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (if4.busy && k < 50) begin
      @(negedge clk_in);
      k++;
    end
    chk(name, 32'(k < 50), 32'd1);
  endtask

  // park on the first cycle of the ones-digit window
  task automatic align_ones(input string name);
    int k = 0;
    while (en4 != 4'b0111 && k < 100) begin @(negedge clk_in); k++; end
    while (en4 == 4'b0111 && k < 100) begin @(negedge clk_in); k++; end
    chk(name, 32'(k < 100), 32'd1);
  endtask

  logic [6:0] seq3 [4];
  logic [3:0] en_seq [4];
  logic [6:0] seq6 [4];

  initial begin
    int cnt;
    seq3   = '{7'b0110000, 7'b0100100, 7'b1000000, 7'b1111001};
    en_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef LEADING_ZERO_BLANK_EN
    seq6   = '{7'b1111000, 7'h7F, 7'h7F, 7'h7F};
`else
    seq6   = '{7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000};
`endif

    // reset values
    tick(3);
    chk("rst_busy", 32'(if4.busy), 32'd0);
    chk("rst_bcd",  32'(if4.bcd), 32'd0);
    chk("rst_ovf",  32'(if4.overflow), 32'd0);
    chk("rst_en",   32'(en4), 32'b1110);
    chk("rst_seg",  32'(seg4), 32'b1000000);
    rst_n = 1'b1;
    tick(2);

    // 573: busy window length and result
    load(573);
    cnt = 0;
    while (if4.busy && cnt < 50) begin cnt++; @(negedge clk_in); end
    chk("busy_cycles", 32'(cnt), 32'd11);
    chk("bcd_573", 32'(if4.bcd), 32'h0573);
    chk("ovf_573", 32'(if4.overflow), 32'd0);

    // 1023 and the scan sequence
    load(1023);
    wait_idle("idle_1023");
    chk("bcd_1023", 32'(if4.bcd), 32'h1023);
    align_ones("align_1023");
    for (int j = 0; j < 4; j++) begin
      chk("scan_seg", 32'(seg4), 32'(seq3[j]));
      chk("scan_en",  32'(en4), 32'(en_seq[j]));
      tick(4);
    end

    // strobe while busy is dropped
    load(573);
    tick(2);
    value = WIDTH'(42);
    value_valid = 1'b1;
    @(negedge clk_in);
    value_valid = 1'b0;
    wait_idle("idle_ignore");
    chk("bcd_ignore", 32'(if4.bcd), 32'h0573);

    // reset on the 5th busy cycle aborts
    load(999);
    tick(4);
    chk("busy_pre_rst", 32'(if4.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk_in);
    chk("abort_busy", 32'(if4.busy), 32'd0);
    chk("abort_bcd",  32'(if4.bcd), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // overflow on the 3-digit instance
    load(1000);
    wait_idle("idle_1000");
    chk("ovf3_1000", 32'(if3.overflow), 32'd1);
    chk("ovf4_1000", 32'(if4.overflow), 32'd0);
    chk("bcd4_1000", 32'(if4.bcd), 32'h1000);
    for (int j = 0; j < 12; j++) begin
      chk("dash3", 32'(seg3), 32'b0111111);
      tick(1);
    end

    // value 7: leading digits
    load(7);
    wait_idle("idle_7");
    chk("bcd_7", 32'(if4.bcd), 32'h0007);
    align_ones("align_7");
    for (int j = 0; j < 4; j++) begin
      chk("lead_seg", 32'(seg4), 32'(seq6[j]));
      tick(4);
    end

    // back-to-back loads at the earliest accepted edge
    for (int j = 0; j < 4; j++) begin
      load($urandom_range(0, 1023));
      wait_idle("idle_rand");
    end
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
